// File: rtl/control_unit.sv
// Hardwired Moore control unit: a three-state fetch (T0-T2), then a per-class
// execute sequence (T3-T7), or HALT until reset.
module control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic        PC_out,
  output logic        MDR_out,
  output logic        ZLow_out,
  output logic        ZHigh_out,
  output logic        C_out,
  output logic        reg_out_en,
  output logic [3:0]  reg_out_sel,
  output logic        reg_in_en,
  output logic [3:0]  reg_in_sel,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        Read,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        PC_enable,
  output logic        IncPC,
  output logic        HI_enable,
  output logic        LO_enable,
  output logic        CON_enable,
  output logic        RAM_read_enable,
  output logic        RAM_write_enable,
  output logic [4:0]  opcode,
  output logic        run,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3,
    T4 = 4'd4, T5 = 4'd5, T6 = 4'd6, T7 = 4'd7, HALT = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    C_LD, C_ST, C_ALU, C_IMM, C_MULDIV, C_BR, C_NOP, C_HALT
  } class_t;

  typedef struct packed {
    logic       pc_out, mdr_out, zlow_out, zhigh_out, c_out;
    logic       reg_out_en;
    logic [3:0] reg_out_sel;
    logic       reg_in_en;
    logic [3:0] reg_in_sel;
    logic       mar_en, mdr_en, read, ir_en, y_en, z_en, pc_en, inc_pc;
    logic       hi_en, lo_en, con_en, ram_rd, ram_wr;
    logic [4:0] opcode;
  } ctrl_t;

  state_t     state_q, state_d;
  class_t     cls;
  ctrl_t      ctrl, ctrl_o;
  logic [4:0] op, imm_op;
  logic [3:0] ra, rb, rc;
  logic       unused_ir;

  assign op        = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign unused_ir = ^ir[14:0];

  always_comb begin
    cls = C_NOP;
    if (op == 5'd0)                      cls = C_LD;
    else if (op == 5'd1)                 cls = C_ST;
    else if (op >= 5'd2 && op <= 5'd10)  cls = C_ALU;
    else if (op >= 5'd11 && op <= 5'd13) cls = C_IMM;
    else if (op == 5'd14 || op == 5'd15) cls = C_MULDIV;
    else if (op == 5'd16)                cls = C_BR;
    else if (op == 5'd27)                cls = C_HALT;
  end

  // Immediate forms reuse the ALU code of their register counterpart.
  always_comb begin
    case (op)
      5'd11:   imm_op = 5'd2;
      5'd12:   imm_op = 5'd4;
      default: imm_op = 5'd5;
    endcase
  end

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    case (state_q)
      T0: begin
        ctrl.pc_out = 1'b1; ctrl.mar_en = 1'b1; ctrl.inc_pc = 1'b1;
        state_d = T1;
      end
      T1: begin
        ctrl.ram_rd = 1'b1; ctrl.read = 1'b1; ctrl.mdr_en = 1'b1;
        state_d = T2;
      end
      T2: begin
        ctrl.mdr_out = 1'b1; ctrl.ir_en = 1'b1;
        state_d = T3;
      end
      T3: begin
        state_d = T4;
        case (cls)
          C_NOP:  state_d = T0;
          C_HALT: state_d = HALT;
          C_BR: begin
            ctrl.reg_out_en = 1'b1; ctrl.reg_out_sel = ra; ctrl.con_en = 1'b1;
          end
          C_MULDIV: begin
            ctrl.reg_out_en = 1'b1; ctrl.reg_out_sel = ra; ctrl.y_en = 1'b1;
          end
          default: begin
            ctrl.reg_out_en = 1'b1; ctrl.reg_out_sel = rb; ctrl.y_en = 1'b1;
          end
        endcase
      end
      T4: begin
        state_d = T5;
        ctrl.z_en = 1'b1;
        case (cls)
          C_ALU, C_MULDIV: begin
            ctrl.reg_out_en = 1'b1;
            ctrl.reg_out_sel = (cls == C_ALU) ? rc : rb;
            ctrl.opcode = op;
          end
          C_IMM: begin
            ctrl.c_out = 1'b1; ctrl.opcode = imm_op;
          end
          C_BR: begin
            ctrl.z_en = 1'b0; ctrl.pc_out = 1'b1; ctrl.y_en = 1'b1;
          end
          default: begin
            ctrl.c_out = 1'b1; ctrl.opcode = 5'd2;
          end
        endcase
      end
      T5: begin
        state_d = T6;
        case (cls)
          C_ALU, C_IMM: begin
            ctrl.zlow_out = 1'b1; ctrl.reg_in_en = 1'b1; ctrl.reg_in_sel = ra;
            state_d = T0;
          end
          C_MULDIV: begin
            ctrl.zlow_out = 1'b1; ctrl.lo_en = 1'b1;
          end
          C_BR: begin
            ctrl.c_out = 1'b1; ctrl.opcode = 5'd2; ctrl.z_en = 1'b1;
          end
          C_LD, C_ST: begin
            ctrl.zlow_out = 1'b1; ctrl.mar_en = 1'b1;
          end
          default: state_d = T0;
        endcase
      end
      T6: begin
        state_d = T0;
        case (cls)
          C_MULDIV: begin
            ctrl.zhigh_out = 1'b1; ctrl.hi_en = 1'b1;
          end
          C_LD: begin
            ctrl.ram_rd = 1'b1; ctrl.read = 1'b1; ctrl.mdr_en = 1'b1;
            state_d = T7;
          end
          C_ST: begin
            ctrl.reg_out_en = 1'b1; ctrl.reg_out_sel = ra; ctrl.ram_wr = 1'b1;
          end
          C_BR: begin
            ctrl.zlow_out = 1'b1; ctrl.pc_en = con_ff;
          end
          default: ;
        endcase
      end
      T7: begin
        ctrl.mdr_out = 1'b1; ctrl.reg_in_en = 1'b1; ctrl.reg_in_sel = ra;
        state_d = T0;
      end
      HALT:    state_d = HALT;
      default: state_d = T0;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= T0;
    else      state_q <= state_d;
  end

  // Reset parks the FSM in T0 but the T0 strobes must stay quiet until clr rises.
  assign ctrl_o = clr ? ctrl : '0;

  assign PC_out           = ctrl_o.pc_out;
  assign MDR_out          = ctrl_o.mdr_out;
  assign ZLow_out         = ctrl_o.zlow_out;
  assign ZHigh_out        = ctrl_o.zhigh_out;
  assign C_out            = ctrl_o.c_out;
  assign reg_out_en       = ctrl_o.reg_out_en;
  assign reg_out_sel      = ctrl_o.reg_out_sel;
  assign reg_in_en        = ctrl_o.reg_in_en;
  assign reg_in_sel       = ctrl_o.reg_in_sel;
  assign MAR_enable       = ctrl_o.mar_en;
  assign MDR_enable       = ctrl_o.mdr_en;
  assign Read             = ctrl_o.read;
  assign IR_enable        = ctrl_o.ir_en;
  assign Y_enable         = ctrl_o.y_en;
  assign Z_enable         = ctrl_o.z_en;
  assign PC_enable        = ctrl_o.pc_en;
  assign IncPC            = ctrl_o.inc_pc;
  assign HI_enable        = ctrl_o.hi_en;
  assign LO_enable        = ctrl_o.lo_en;
  assign CON_enable       = ctrl_o.con_en;
  assign RAM_read_enable  = ctrl_o.ram_rd;
  assign RAM_write_enable = ctrl_o.ram_wr;
  assign opcode           = ctrl_o.opcode;
  assign run              = (state_q != HALT);
  assign state            = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle expected output table plus
// hand sequences for halt and reset-in-flight.
module tb_control_unit;

  logic        clk, clr, con_ff;
  logic [31:0] ir;
  logic        PC_out, MDR_out, ZLow_out, ZHigh_out, C_out;
  logic        reg_out_en, reg_in_en;
  logic [3:0]  reg_out_sel, reg_in_sel, state;
  logic        MAR_enable, MDR_enable, Read, IR_enable, Y_enable, Z_enable;
  logic        PC_enable, IncPC, HI_enable, LO_enable, CON_enable;
  logic        RAM_read_enable, RAM_write_enable, run;
  logic [4:0]  opcode;

  control_unit dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff),
    .PC_out(PC_out), .MDR_out(MDR_out), .ZLow_out(ZLow_out),
    .ZHigh_out(ZHigh_out), .C_out(C_out),
    .reg_out_en(reg_out_en), .reg_out_sel(reg_out_sel),
    .reg_in_en(reg_in_en), .reg_in_sel(reg_in_sel),
    .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .Read(Read),
    .IR_enable(IR_enable), .Y_enable(Y_enable), .Z_enable(Z_enable),
    .PC_enable(PC_enable), .IncPC(IncPC), .HI_enable(HI_enable),
    .LO_enable(LO_enable), .CON_enable(CON_enable),
    .RAM_read_enable(RAM_read_enable), .RAM_write_enable(RAM_write_enable),
    .opcode(opcode), .run(run), .state(state)
  );

  // Strobe bit positions inside the 20-bit packed strobe word.
  localparam logic [19:0] PCO  = 20'h80000, MDRO = 20'h40000, ZLO  = 20'h20000;
  localparam logic [19:0] ZHO  = 20'h10000, CO   = 20'h08000, RO   = 20'h04000;
  localparam logic [19:0] RI   = 20'h02000, MARE = 20'h01000, MDRE = 20'h00800;
  localparam logic [19:0] RD   = 20'h00400, IRE  = 20'h00200, YE   = 20'h00100;
  localparam logic [19:0] ZE   = 20'h00080, PCE  = 20'h00040, INC  = 20'h00020;
  localparam logic [19:0] HIE  = 20'h00010, LOE  = 20'h00008, CONE = 20'h00004;
  localparam logic [19:0] RRD  = 20'h00002, RWR  = 20'h00001;

  typedef struct {
    logic [31:0] ir;
    logic        con;
    logic [3:0]  st;
    logic [19:0] strb;
    logic [3:0]  osel;
    logic [3:0]  isel;
    logic [4:0]  opc;
    logic        run;
  } vec_t;

  vec_t tbl[$];
  int   tests = 0;
  int   fails = 0;
  logic mon_en = 1'b0;
  logic st_win = 1'b0;
  logic wr_seen = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [37:0] got_vec();
    logic [19:0] s;
    s = {PC_out, MDR_out, ZLow_out, ZHigh_out, C_out, reg_out_en, reg_in_en,
         MAR_enable, MDR_enable, Read, IR_enable, Y_enable, Z_enable, PC_enable,
         IncPC, HI_enable, LO_enable, CON_enable, RAM_read_enable, RAM_write_enable};
    return {state, run, opcode, reg_in_sel, reg_out_sel, s};
  endfunction

  function automatic logic [37:0] exp_vec(input vec_t v);
    return {v.st, v.run, v.opc, v.isel, v.osel, v.strb};
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c);
    return {op, a, b, c, 15'd0};
  endfunction

  function automatic vec_t mk_row(input logic [31:0] i, input logic c, input logic [3:0] s,
                                  input logic [19:0] b, input logic [3:0] os,
                                  input logic [3:0] is, input logic [4:0] oc,
                                  input logic r);
    vec_t v;
    v.ir = i; v.con = c; v.st = s; v.strb = b;
    v.osel = os; v.isel = is; v.opc = oc; v.run = r;
    return v;
  endfunction

  task automatic row(input logic [31:0] i, input logic c, input logic [3:0] s,
                     input logic [19:0] b, input logic [3:0] os,
                     input logic [3:0] is, input logic [4:0] oc);
    tbl.push_back(mk_row(i, c, s, b, os, is, oc, 1'b1));
  endtask

  task automatic fetch(input logic [31:0] i, input logic c);
    row(i, c, 4'd0, PCO | MARE | INC, 4'd0, 4'd0, 5'd0);
    row(i, c, 4'd1, RRD | RD | MDRE, 4'd0, 4'd0, 5'd0);
    row(i, c, 4'd2, MDRO | IRE, 4'd0, 4'd0, 5'd0);
  endtask

  // Called mid-cycle (just after a falling edge); leaves at the next falling edge.
  task automatic apply_row(input vec_t v, input string name);
    ir = v.ir;
    con_ff = v.con;
    #1;
    chk(name, 64'(got_vec()), 64'(exp_vec(v)));
    @(negedge clk);
  endtask

  // Bus-drive one-hot and RAM read/write exclusion, every cycle.
  always @(negedge clk) begin
    #2;
    if (mon_en)
      chk("bus_onehot",
          64'(($countones({PC_out, MDR_out, ZLow_out, ZHigh_out, C_out, reg_out_en}) <= 1)
              && !(RAM_read_enable && RAM_write_enable)), 64'd1);
  end

  always @(posedge RAM_write_enable) if (st_win) wr_seen = 1'b1;

  initial begin
    logic [31:0] i_add, i_ld, i_br, i_mul, i_div, i_andi, i_ori, i_rol;
    logic [31:0] i_st, i_nop, i_und, i_halt;
    vec_t rst_v;

    i_add  = mk_ir(5'd2, 4'd3, 4'd1, 4'd2);
    i_ld   = mk_ir(5'd0, 4'd4, 4'd2, 4'd0);
    i_br   = mk_ir(5'd16, 4'd7, 4'd0, 4'd0);
    i_mul  = mk_ir(5'd14, 4'd5, 4'd6, 4'd0);
    i_div  = mk_ir(5'd15, 4'd1, 4'd2, 4'd0);
    i_andi = mk_ir(5'd12, 4'd9, 4'd10, 4'd0);
    i_ori  = mk_ir(5'd13, 4'd1, 4'd15, 4'd0);
    i_rol  = mk_ir(5'd10, 4'd15, 4'd14, 4'd13);
    i_st   = mk_ir(5'd1, 4'd8, 4'd3, 4'd0);
    i_nop  = mk_ir(5'd26, 4'd1, 4'd2, 4'd3);
    i_und  = mk_ir(5'd31, 4'd5, 4'd5, 4'd5);
    i_halt = mk_ir(5'd27, 4'd0, 4'd0, 4'd0);
    rst_v  = mk_row(32'd0, 1'b0, 4'd0, 20'd0, 4'd0, 4'd0, 5'd0, 1'b1);

    fetch(i_add, 1'b0);
    row(i_add, 1'b0, 4'd3, RO | YE, 4'd1, 4'd0, 5'd0);
    row(i_add, 1'b0, 4'd4, RO | ZE, 4'd2, 4'd0, 5'd2);
    row(i_add, 1'b0, 4'd5, ZLO | RI, 4'd0, 4'd3, 5'd0);

    fetch(i_ld, 1'b0);
    row(i_ld, 1'b0, 4'd3, RO | YE, 4'd2, 4'd0, 5'd0);
    row(i_ld, 1'b0, 4'd4, CO | ZE, 4'd0, 4'd0, 5'd2);
    row(i_ld, 1'b0, 4'd5, ZLO | MARE, 4'd0, 4'd0, 5'd0);
    row(i_ld, 1'b0, 4'd6, RRD | RD | MDRE, 4'd0, 4'd0, 5'd0);
    row(i_ld, 1'b0, 4'd7, MDRO | RI, 4'd0, 4'd4, 5'd0);

    for (int c = 0; c < 2; c++) begin
      fetch(i_br, 1'(c));
      row(i_br, 1'(c), 4'd3, RO | CONE, 4'd7, 4'd0, 5'd0);
      row(i_br, 1'(c), 4'd4, PCO | YE, 4'd0, 4'd0, 5'd0);
      row(i_br, 1'(c), 4'd5, CO | ZE, 4'd0, 4'd0, 5'd2);
      row(i_br, 1'(c), 4'd6, (c == 1) ? (ZLO | PCE) : ZLO, 4'd0, 4'd0, 5'd0);
    end

    fetch(i_mul, 1'b0);
    row(i_mul, 1'b0, 4'd3, RO | YE, 4'd5, 4'd0, 5'd0);
    row(i_mul, 1'b0, 4'd4, RO | ZE, 4'd6, 4'd0, 5'd14);
    row(i_mul, 1'b0, 4'd5, ZLO | LOE, 4'd0, 4'd0, 5'd0);
    row(i_mul, 1'b0, 4'd6, ZHO | HIE, 4'd0, 4'd0, 5'd0);

    fetch(i_div, 1'b0);
    row(i_div, 1'b0, 4'd3, RO | YE, 4'd1, 4'd0, 5'd0);
    row(i_div, 1'b0, 4'd4, RO | ZE, 4'd2, 4'd0, 5'd15);
    row(i_div, 1'b0, 4'd5, ZLO | LOE, 4'd0, 4'd0, 5'd0);
    row(i_div, 1'b0, 4'd6, ZHO | HIE, 4'd0, 4'd0, 5'd0);

    fetch(i_andi, 1'b0);
    row(i_andi, 1'b0, 4'd3, RO | YE, 4'd10, 4'd0, 5'd0);
    row(i_andi, 1'b0, 4'd4, CO | ZE, 4'd0, 4'd0, 5'd4);
    row(i_andi, 1'b0, 4'd5, ZLO | RI, 4'd0, 4'd9, 5'd0);

    fetch(i_ori, 1'b0);
    row(i_ori, 1'b0, 4'd3, RO | YE, 4'd15, 4'd0, 5'd0);
    row(i_ori, 1'b0, 4'd4, CO | ZE, 4'd0, 4'd0, 5'd5);
    row(i_ori, 1'b0, 4'd5, ZLO | RI, 4'd0, 4'd1, 5'd0);

    fetch(i_rol, 1'b0);
    row(i_rol, 1'b0, 4'd3, RO | YE, 4'd14, 4'd0, 5'd0);
    row(i_rol, 1'b0, 4'd4, RO | ZE, 4'd13, 4'd0, 5'd10);
    row(i_rol, 1'b0, 4'd5, ZLO | RI, 4'd0, 4'd15, 5'd0);

    fetch(i_st, 1'b0);
    row(i_st, 1'b0, 4'd3, RO | YE, 4'd3, 4'd0, 5'd0);
    row(i_st, 1'b0, 4'd4, CO | ZE, 4'd0, 4'd0, 5'd2);
    row(i_st, 1'b0, 4'd5, ZLO | MARE, 4'd0, 4'd0, 5'd0);
    row(i_st, 1'b0, 4'd6, RO | RWR, 4'd8, 4'd0, 5'd0);

    fetch(i_nop, 1'b0);
    row(i_nop, 1'b0, 4'd3, 20'd0, 4'd0, 4'd0, 5'd0);
    fetch(i_und, 1'b0);
    row(i_und, 1'b0, 4'd3, 20'd0, 4'd0, 4'd0, 5'd0);

    // Reset: outputs quiet while clr is low.
    clr = 1'b0; ir = 32'd0; con_ff = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("reset_state", 64'(got_vec()), 64'(exp_vec(rst_v)));
    @(negedge clk);
    clr = 1'b1;
    mon_en = 1'b1;

    foreach (tbl[i]) apply_row(tbl[i], $sformatf("vec%0d_op%0d_T%0d", i, tbl[i].ir[31:27], tbl[i].st));

    // Halt: parks with run=0 until reset.
    apply_row(mk_row(i_halt, 1'b0, 4'd0, PCO | MARE | INC, 4'd0, 4'd0, 5'd0, 1'b1), "halt_T0");
    apply_row(mk_row(i_halt, 1'b0, 4'd1, RRD | RD | MDRE, 4'd0, 4'd0, 5'd0, 1'b1), "halt_T1");
    apply_row(mk_row(i_halt, 1'b0, 4'd2, MDRO | IRE, 4'd0, 4'd0, 5'd0, 1'b1), "halt_T2");
    apply_row(mk_row(i_halt, 1'b0, 4'd3, 20'd0, 4'd0, 4'd0, 5'd0, 1'b1), "halt_T3");
    for (int k = 0; k < 22; k++)
      apply_row(mk_row(i_halt, 1'b0, 4'd8, 20'd0, 4'd0, 4'd0, 5'd0, 1'b0), $sformatf("halt_park%0d", k));
    #2 clr = 1'b0;
    #1 chk("halt_clr_async", 64'(got_vec()), 64'(exp_vec(rst_v)));
    @(negedge clk);
    clr = 1'b1;

    // First edge after release performs T0; then reset lands in T4 of st.
    st_win = 1'b1;
    apply_row(mk_row(i_st, 1'b0, 4'd0, PCO | MARE | INC, 4'd0, 4'd0, 5'd0, 1'b1), "rel_T0");
    apply_row(mk_row(i_st, 1'b0, 4'd1, RRD | RD | MDRE, 4'd0, 4'd0, 5'd0, 1'b1), "rel_T1");
    apply_row(mk_row(i_st, 1'b0, 4'd2, MDRO | IRE, 4'd0, 4'd0, 5'd0, 1'b1), "st_T2");
    apply_row(mk_row(i_st, 1'b0, 4'd3, RO | YE, 4'd3, 4'd0, 5'd0, 1'b1), "st_T3");
    #1 chk("st_T4", 64'(got_vec()),
           64'(exp_vec(mk_row(i_st, 1'b0, 4'd4, CO | ZE, 4'd0, 4'd0, 5'd2, 1'b1))));
    #1 clr = 1'b0;
    #1 chk("st_clr_async", 64'(got_vec()), 64'(exp_vec(rst_v)));
    @(negedge clk);
    #1 chk("st_clr_held", 64'(got_vec()), 64'(exp_vec(rst_v)));
    @(negedge clk);
    clr = 1'b1;
    apply_row(mk_row(i_nop, 1'b0, 4'd0, PCO | MARE | INC, 4'd0, 4'd0, 5'd0, 1'b1), "post_T0");
    apply_row(mk_row(i_nop, 1'b0, 4'd1, RRD | RD | MDRE, 4'd0, 4'd0, 5'd0, 1'b1), "post_T1");
    apply_row(mk_row(i_nop, 1'b0, 4'd2, MDRO | IRE, 4'd0, 4'd0, 5'd0, 1'b1), "post_T2");
    apply_row(mk_row(i_nop, 1'b0, 4'd3, 20'd0, 4'd0, 4'd0, 5'd0, 1'b1), "post_T3");
    apply_row(mk_row(i_nop, 1'b0, 4'd0, PCO | MARE | INC, 4'd0, 4'd0, 5'd0, 1'b1), "post_T0b");
    st_win = 1'b0;
    chk("st_no_write", 64'(wr_seen), 64'd0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have one clock and asynchronous active-low reset: clk (rising edge), clr (0 = reset).
REQ-002 SHALL have port clk, input, 1 bit: system clock.
REQ-003 SHALL have port clr, input, 1 bit: asynchronous reset, active-low.
REQ-004 SHALL have port ir, input, 32 bits: instruction register contents. Fields: op=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15].
REQ-005 SHALL have port con_ff, input, 1 bit: branch condition flag from the CON logic.
REQ-006 SHALL have outputs PC_out, MDR_out, ZLow_out, ZHigh_out and C_out, 1 bit each: bus-drive selects.
REQ-007 SHALL have outputs reg_out_en (1 bit) and reg_out_sel (4 bits): drive register file R[sel] onto the bus.
REQ-008 SHALL have outputs reg_in_en (1 bit) and reg_in_sel (4 bits): load R[sel] from the bus.
REQ-009 SHALL have 1-bit outputs MAR_enable, MDR_enable, Read, IR_enable, Y_enable, Z_enable, PC_enable, IncPC, HI_enable, LO_enable, CON_enable, RAM_read_enable and RAM_write_enable: datapath strobes.
REQ-010 SHALL have output opcode, 5 bits: ALU operation select.
REQ-011 SHALL have output run, 1 bit: 1 while executing, 0 when halted.
REQ-012 SHALL have output state, 4 bits: current state encoding, for debug.

Function
REQ-013 SHALL be a Moore FSM with states T0..T7 and HALT; every output SHALL be a registered or state-decoded signal, with no combinational path from ir to state.
REQ-014 Fetch SHALL run as follows:
- T0: PC_out, MAR_enable, IncPC.
- T1: RAM_read_enable, Read, MDR_enable.
- T2: MDR_out, IR_enable.
- T2 SHALL always go to T3.
REQ-015 Decode SHALL use ir sampled in T3; ir SHALL be treated as stable from T3 until the next T0.
REQ-016 Opcode classes SHALL be:
- 00000 ld
- 00001 st
- 00010–01010 ALU register-register (add, sub, and, or, shr, shra, shl, ror, rol)
- 01011–01101 ALU immediate (addi, andi, ori)
- 01110 mul
- 01111 div
- 10000 br
- 11010 nop
- 11011 halt
- all other opcodes SHALL execute as nop.
REQ-017 ALU register-register SHALL run:
- T3: reg_out rb, Y_enable.
- T4: reg_out rc, opcode=op, Z_enable.
- T5: ZLow_out, reg_in ra; then T0.
REQ-018 ALU immediate SHALL match REQ-017, except T4 drives C_out instead of rc and uses opcode = the matching register op (addi→add, andi→and, ori→or).
REQ-019 mul/div SHALL run:
- T3: reg_out ra, Y_enable.
- T4: reg_out rb, opcode=op, Z_enable.
- T5: ZLow_out, LO_enable.
- T6: ZHigh_out, HI_enable; then T0.
REQ-020 ld SHALL run:
- T3: reg_out rb, Y_enable.
- T4: C_out, opcode=00010 (add), Z_enable.
- T5: ZLow_out, MAR_enable.
- T6: RAM_read_enable, Read, MDR_enable.
- T7: MDR_out, reg_in ra; then T0.
REQ-021 st SHALL run T3–T5 as ld, then T6: reg_out ra, RAM_write_enable; then T0.
REQ-022 br SHALL run:
- T3: reg_out ra, CON_enable.
- T4: PC_out, Y_enable.
- T5: C_out, opcode=add, Z_enable.
- T6: ZLow_out, with PC_enable only if con_ff=1; then T0.
REQ-023 nop SHALL go from T3 to T0 with no strobes asserted.
REQ-024 halt SHALL go from T3 to HALT. HALT SHALL assert no strobes, drive run=0, and be left only by reset.
REQ-025 At most one bus-drive select (PC_out, MDR_out, ZLow_out, ZHigh_out, C_out, reg_out_en) SHALL be 1 in any cycle.
REQ-026 Unused strobes SHALL be 0; opcode SHALL be 00000 when Z_enable=0; reg_*_sel SHALL be 0 when the matching enable is 0.
REQ-027 RAM_read_enable and RAM_write_enable SHALL never both be 1.

Reset
REQ-028 clr=0 SHALL force state=T0, run=1 and all strobes/selects/opcode to 0 immediately, regardless of clk.
REQ-029 Reset asserted mid-instruction or in HALT SHALL abandon the instruction; the first rising clk edge after clr returns high SHALL leave T0, so that edge performs the T0 strobes.
REQ-030 run SHALL be 1 in every state except HALT.

Verification
REQ-031 Reset then add (op=00010, ra=3, rb=1, rc=2) SHALL give: T0..T5 in 6 cycles; T5 reg_in_en=1 with reg_in_sel=3; return to T0 on cycle 7.
REQ-032 ld (ra=4, rb=2) SHALL give: T5 ZLow_out+MAR_enable; T6 Read+RAM_read_enable; T7 MDR_out with reg_in_sel=4; 8 cycles total.
REQ-033 br with con_ff=0 then con_ff=1 SHALL give PC_enable=0 in T6 for the first and PC_enable=1 in T6 for the second; both 7 cycles.
REQ-034 mul (ra=5, rb=6) SHALL give LO_enable in T5 and HI_enable in T6, never in the same cycle.
REQ-035 halt SHALL give run=0 from the cycle after T3 for 20+ cycles with all strobes 0; clr pulse low SHALL then give run=1, state=T0.
REQ-036 clr=0 asserted in T4 of st SHALL give RAM_write_enable never asserted and state=T0 immediately; a bus-driver one-hot assertion SHALL be checked every cycle.
